// File: rtl/cascade_slave_responder_if.sv
// Cascade acknowledge bus between a slave PIC's responder and its surroundings.
// The slave modport is the responder's view; the master modport is the view
// of whatever drives INTA/CAS and consumes the vector and ISR request.
interface cascade_slave_responder_if;
  // CPU / master PIC side
  logic       inta_n;       // asynchronous active-low INTA pulse
  logic [2:0] cas_in;       // cascade ID broadcast by the master

  // Configuration and priority-resolver side
  logic [2:0] slave_id;     // this slave's ID (ICW3)
  logic [4:0] vector_base;  // T7..T3 (ICW2)
  logic       ir_valid;     // an unmasked request is pending
  logic [2:0] ir_level;     // highest-priority pending level
  logic       enable;       // initialisation complete

  // Responses
  logic [7:0] data_out;     // vector byte
  logic       data_oe;      // data bus drive enable
  logic       isr_set;      // one-cycle request to set ISR bit isr_level
  logic [2:0] isr_level;    // level paired with isr_set
  logic       spurious;     // the vector being driven is the IR7 spurious one
  logic       abort;        // one-cycle pulse when the gap between pulses times out
  logic       busy;         // an acknowledge sequence is in progress

  modport slave (
    input  inta_n, cas_in, slave_id, vector_base, ir_valid, ir_level, enable,
    output data_out, data_oe, isr_set, isr_level, spurious, abort, busy
  );

  modport master (
    output inta_n, cas_in, slave_id, vector_base, ir_valid, ir_level, enable,
    input  data_out, data_oe, isr_set, isr_level, spurious, abort, busy
  );
endinterface

// File: rtl/cascade_slave_responder.sv
// Slave-side responder for the 8259A cascade acknowledge protocol (8086 mode).
// Tracks the two-pulse INTA sequence, latches CAS at the second pulse and,
// when addressed, drives the vector byte and requests the ISR bit be set.
module cascade_slave_responder #(
  parameter int TIMEOUT_CYCLES = 64,  // max cycles allowed between INTA pulses
  parameter int SYNC_STAGES    = 2    // INTA_N synchroniser depth (>= 2)
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  cascade_slave_responder_if.slave    bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,   // waiting for the first INTA pulse
    S_ACK1,   // inside the first INTA pulse
    S_WAIT2,  // gap between pulses, timeout counter running
    S_ACK2    // inside the second INTA pulse, vector driven if addressed
  } state_t;

  // ---------------------------------------------------------------------------
  // INTA_N synchronisation and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;   // synchroniser chain, stage 0 samples the pin
  logic [SYNC_STAGES-1:0] fill_q;   // marks which chain stages hold real samples
  logic                   inta_p_q; // previous synchronised value
  logic                   inta_s;
  logic                   fall_ev;
  logic                   rise_ev;

  assign inta_s = sync_q[SYNC_STAGES-1];

  // Shift INTA_N through the synchroniser and track how far real samples reach.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, exactly like the hardware chain.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '1;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.inta_n};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Keep the previous synchronised level. It is held at 0 until the chain
  // carries genuine samples, so the reset-preset 1s can never pair with a
  // low pin to fake a falling edge after reset release: a pin that is already
  // low when reset lifts must first go high before a fall can be seen.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inta_p_q <= 1'b0;
    end else begin
      inta_p_q <= fill_q[SYNC_STAGES-1] ? inta_s : 1'b0;
    end
  end

  assign fall_ev = inta_p_q & ~inta_s;
  assign rise_ev = ~inta_p_q & inta_s;

  // ---------------------------------------------------------------------------
  // Cascade ID capture
  // ---------------------------------------------------------------------------
  logic [2:0] cas_q;
  logic [2:0] cas_d;
  logic       state_is_wait2;
  logic       cas_match;

  // Capture CAS on the second falling edge; the match is evaluated on the
  // value being captured so the response appears in the very next cycle.
  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    cas_d = cas_q;
    if (bus.enable && state_is_wait2 && fall_ev) begin
      cas_d = bus.cas_in;
    end
  end

  assign cas_match = (cas_d == bus.slave_id);

  // Hold the captured cascade ID.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cas_q <= 3'd0;
    end else begin
      cas_q <= cas_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Acknowledge sequencer with registered outputs
  // ---------------------------------------------------------------------------
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       level_q;
  logic             spur_q;
  logic [7:0]       data_out_q;
  logic             data_oe_q;
  logic             isr_set_q;
  logic [2:0]       isr_level_q;
  logic             spurious_q;
  logic             abort_q;
  logic             busy_q;

  assign state_is_wait2 = (state_q == S_WAIT2);

  // Walk the INTA sequence, freeze the level at the first pulse and produce
  // the vector, ISR request and abort pulses one cycle after each event.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      level_q     <= 3'd0;
      spur_q      <= 1'b0;
      data_out_q  <= 8'd0;
      data_oe_q   <= 1'b0;
      isr_set_q   <= 1'b0;
      isr_level_q <= 3'd0;
      spurious_q  <= 1'b0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // Pulse outputs default low so any assertion lasts exactly one cycle.
      isr_set_q <= 1'b0;
      abort_q   <= 1'b0;

      if (!bus.enable) begin
        // Disarmed: drop any sequence quietly, without abort or ISR request.
        state_q    <= S_IDLE;
        cnt_q      <= '0;
        data_out_q <= 8'd0;
        data_oe_q  <= 1'b0;
        spurious_q <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (fall_ev) begin
              state_q <= S_ACK1;
              busy_q  <= 1'b1;
              // With nothing pending the slave answers with the IR7 vector.
              if (bus.ir_valid) begin
                level_q <= bus.ir_level;
                spur_q  <= 1'b0;
              end else begin
                level_q <= 3'd7;
                spur_q  <= 1'b1;
              end
            end
          end

          S_ACK1: begin
            if (rise_ev) begin
              state_q <= S_WAIT2;
              cnt_q   <= '0;
            end
          end

          S_WAIT2: begin
            // A second pulse arriving on the timeout cycle still counts.
            if (fall_ev) begin
              state_q <= S_ACK2;
              if (cas_match) begin
                data_out_q  <= {bus.vector_base, level_q};
                data_oe_q   <= 1'b1;
                spurious_q  <= spur_q;
                isr_set_q   <= ~spur_q;
                if (!spur_q) begin
                  isr_level_q <= level_q;
                end
              end
            end else if (cnt_q == CNT_LAST) begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
              abort_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end

          S_ACK2: begin
            // Release the data bus one cycle after the second pulse ends,
            // whether or not this slave was the one addressed.
            if (rise_ev) begin
              state_q    <= S_IDLE;
              data_out_q <= 8'd0;
              data_oe_q  <= 1'b0;
              spurious_q <= 1'b0;
              busy_q     <= 1'b0;
            end
          end

          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.data_oe   = data_oe_q;
  assign bus.isr_set   = isr_set_q;
  assign bus.isr_level = isr_level_q;
  assign bus.spurious  = spurious_q;
  assign bus.abort     = abort_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_cascade_slave_responder.sv
// Self-checking bench for cascade_slave_responder: directed scenarios from the
// acknowledge protocol plus randomised sequences checked against an outcome
// model derived from the protocol rules.
module tb_cascade_slave_responder;

  logic clk;
  logic rst_n;

  cascade_slave_responder_if bus();

  cascade_slave_responder dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Event counters observed on the falling edge.
  int         isr_cnt   = 0;
  int         abort_cnt = 0;
  logic [2:0] last_isr_level = 3'd0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.isr_set) begin
        isr_cnt        = isr_cnt + 1;
        last_isr_level = bus.isr_level;
      end
      if (bus.abort) abort_cnt = abort_cnt + 1;
    end
  end

  // Advance n rising edges and drive just after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    @(posedge clk);
    #1;
    isr_cnt   = 0;
    abort_cnt = 0;
  endtask

  task automatic configure(input logic [2:0] sid, input logic [4:0] vb);
    bus.slave_id    = sid;
    bus.vector_base = vb;
  endtask

  // One full two-pulse acknowledge. Expectations come from the protocol rules:
  // addressed iff CAS at the second pulse equals SLAVE_ID; the vector uses the
  // level pending at the first pulse (7 if none); ISR is requested only for a
  // real (non-spurious) level when addressed.
  task automatic do_ack(input string name, input logic [2:0] cas, input bit valid1,
                        input logic [2:0] lvl1, input logic [2:0] lvl2);
    bit         exp_match;
    logic [7:0] exp_vec;
    int         exp_isr;
    exp_match = (cas == bus.slave_id);
    exp_vec   = {bus.vector_base, (valid1 ? lvl1 : 3'd7)};
    exp_isr   = (exp_match && valid1) ? 1 : 0;

    clear_counts();
    bus.ir_valid = valid1;
    bus.ir_level = lvl1;
    bus.cas_in   = 3'($urandom);

    // First pulse
    bus.inta_n = 1'b0;
    cyc(4 + $urandom_range(0, 3));
    @(negedge clk);
    total_cnt++;
    if (bus.busy !== 1'b1) $display("FAIL %s busy_pulse1: got %b want 1", name, bus.busy);
    else pass_cnt++;
    total_cnt++;
    if (bus.data_oe !== 1'b0) $display("FAIL %s oe_pulse1: got %b want 0", name, bus.data_oe);
    else pass_cnt++;

    // Gap: the pending level changes and must be ignored
    bus.inta_n   = 1'b1;
    bus.ir_level = lvl2;
    bus.ir_valid = 1'($urandom);
    cyc(4 + $urandom_range(0, 8));

    // Second pulse
    bus.cas_in = cas;
    bus.inta_n = 1'b0;
    cyc(6 + $urandom_range(0, 3));
    @(negedge clk);
    total_cnt++;
    if (bus.data_oe !== exp_match) $display("FAIL %s oe_pulse2: got %b want %b", name, bus.data_oe, exp_match);
    else pass_cnt++;
    if (exp_match) begin
      total_cnt++;
      if (bus.data_out !== exp_vec) $display("FAIL %s vector: got %h want %h", name, bus.data_out, exp_vec);
      else pass_cnt++;
      total_cnt++;
      if (bus.spurious !== !valid1) $display("FAIL %s spurious: got %b want %b", name, bus.spurious, !valid1);
      else pass_cnt++;
    end

    // Release and let the sequence close
    bus.cas_in = 3'($urandom);
    bus.inta_n = 1'b1;
    cyc(6);
    @(negedge clk);
    total_cnt++;
    if (bus.data_oe !== 1'b0 || bus.busy !== 1'b0 || bus.data_out !== 8'd0 || bus.spurious !== 1'b0)
      $display("FAIL %s after_release: got oe=%b busy=%b out=%h spur=%b want all 0",
               name, bus.data_oe, bus.busy, bus.data_out, bus.spurious);
    else pass_cnt++;
    total_cnt++;
    if (isr_cnt !== exp_isr) $display("FAIL %s isr_count: got %0d want %0d", name, isr_cnt, exp_isr);
    else pass_cnt++;
    if (exp_isr == 1) begin
      total_cnt++;
      if (last_isr_level !== lvl1) $display("FAIL %s isr_level: got %0d want %0d", name, last_isr_level, lvl1);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.inta_n = 1'b1; bus.cas_in = 3'd0; bus.ir_valid = 1'b0; bus.ir_level = 3'd0;
    bus.enable = 1'b1;
    configure(3'd3, 5'b01000);
    #12;
    total_cnt++;
    if ({bus.data_out, bus.data_oe, bus.isr_set, bus.isr_level, bus.spurious, bus.abort, bus.busy} !== 17'd0)
      $display("FAIL reset_outputs: got out=%h oe=%b isr=%b lvl=%0d spur=%b abort=%b busy=%b want all 0",
               bus.data_out, bus.data_oe, bus.isr_set, bus.isr_level, bus.spurious, bus.abort, bus.busy);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(4);
    @(negedge clk);
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL reset_idle: got busy=%b want 0", bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    configure(3'd3, 5'b01000);
    do_ack("matched",   3'd3, 1'b1, 3'd5, 3'd5);
    do_ack("unmatched", 3'd2, 1'b1, 3'd5, 3'd5);
    do_ack("spurious",  3'd3, 1'b0, 3'd4, 3'd1);
    do_ack("freeze",    3'd3, 1'b1, 3'd2, 3'd6);
  endtask

  task automatic test_timeout();
    configure(3'd3, 5'b01000);
    clear_counts();
    bus.ir_valid = 1'b1; bus.ir_level = 3'd1;
    bus.inta_n = 1'b0;
    cyc(5);
    bus.inta_n = 1'b1;
    cyc(70);
    @(negedge clk);
    total_cnt++;
    if (abort_cnt !== 1) $display("FAIL timeout_abort: got %0d pulses want 1", abort_cnt);
    else pass_cnt++;
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.data_oe !== 1'b0)
      $display("FAIL timeout_idle: got busy=%b oe=%b want 0 0", bus.busy, bus.data_oe);
    else pass_cnt++;
    do_ack("after_timeout", 3'd3, 1'b1, 3'd6, 3'd0);
  endtask

  task automatic test_enable();
    configure(3'd5, 5'b10101);
    clear_counts();
    // Disabled: a full sequence is ignored
    bus.enable = 1'b0;
    bus.ir_valid = 1'b1; bus.ir_level = 3'd3; bus.cas_in = 3'd5;
    bus.inta_n = 1'b0; cyc(5);
    bus.inta_n = 1'b1; cyc(5);
    bus.inta_n = 1'b0; cyc(7);
    @(negedge clk);
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.data_oe !== 1'b0)
      $display("FAIL disabled_ignore: got busy=%b oe=%b want 0 0", bus.busy, bus.data_oe);
    else pass_cnt++;
    // Enabling while INTA_N is already low is not a fresh fall
    bus.enable = 1'b1;
    cyc(4);
    bus.inta_n = 1'b1; cyc(6);
    @(negedge clk);
    total_cnt++;
    if (bus.busy !== 1'b0 || isr_cnt !== 0)
      $display("FAIL enable_late: got busy=%b isr=%0d want 0 0", bus.busy, isr_cnt);
    else pass_cnt++;
    // Drop ENABLE mid-sequence: quiet return to idle
    bus.inta_n = 1'b0; cyc(5);
    bus.enable = 1'b0; cyc(2);
    @(negedge clk);
    total_cnt++;
    if (bus.busy !== 1'b0 || abort_cnt !== 0)
      $display("FAIL disable_mid: got busy=%b abort=%0d want 0 0", bus.busy, abort_cnt);
    else pass_cnt++;
    bus.enable = 1'b1;
    cyc(2);
    bus.inta_n = 1'b1; cyc(6);
    do_ack("after_enable", 3'd5, 1'b1, 3'd3, 3'd7);
  endtask

  task automatic test_reset_mid_ack2();
    configure(3'd3, 5'b01000);
    clear_counts();
    bus.ir_valid = 1'b1; bus.ir_level = 3'd5; bus.cas_in = 3'd3;
    bus.inta_n = 1'b0; cyc(5);
    bus.inta_n = 1'b1; cyc(5);
    bus.inta_n = 1'b0; cyc(7);
    @(negedge clk);
    total_cnt++;
    if (bus.data_oe !== 1'b1) $display("FAIL rst_mid_pre: got oe=%b want 1", bus.data_oe);
    else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (bus.data_oe !== 1'b0 || bus.busy !== 1'b0 || bus.data_out !== 8'd0)
      $display("FAIL rst_mid_async: got oe=%b busy=%b out=%h want 0 0 00", bus.data_oe, bus.busy, bus.data_out);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_counts();
    cyc(10);
    @(negedge clk);
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.data_oe !== 1'b0)
      $display("FAIL rst_low_inta: got busy=%b oe=%b want 0 0", bus.busy, bus.data_oe);
    else pass_cnt++;
    bus.inta_n = 1'b1; cyc(6);
    do_ack("after_reset", 3'd3, 1'b1, 3'd4, 3'd1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      logic [2:0] sid;
      logic [2:0] cas;
      sid = 3'($urandom);
      cas = ($urandom_range(0, 1) == 1) ? sid : 3'($urandom);
      configure(sid, 5'($urandom));
      do_ack($sformatf("rand%0d", i), cas, 1'($urandom_range(0, 3) != 0),
             3'($urandom), 3'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_enable();
    test_reset_mid_ack2();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
